// File: rtl/spike_dispatcher.sv
// spike_dispatcher: replays filtered spike addresses to the core as AER events.
// Optional ACK watchdog enabled with `define SPIKE_DISPATCH_TIMEOUT_EN.
`timescale 1ns/1ps

module spike_dispatcher #(
  parameter int N       = 256,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023,
  localparam int M      = $clog2(N),
  localparam int AW     = 2*M+1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             enable_i,
  output logic             FIFO_r_en_o,
  input  logic [M-1:0]     FIFO_r_data_i,
  input  logic             FIFO_empty_i,
  input  logic             filter_done_i,
  output logic             AERIN_REQ_o,
  input  logic             AERIN_ACK_i,
  output logic [AW-1:0]    AERIN_ADDR_o,
  output logic [CNT_W-1:0] event_cnt_o,
  output logic             tick_done_o,
  output logic             busy_o,
  output logic             timeout_err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_ACKLOW = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ren_q, ren_d;
  logic             req_q, req_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

`ifdef SPIKE_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT-1);

  logic [TW-1:0] to_q, to_d;
  logic          terr_q, terr_d;
`endif

  // Next-state, address capture and event counting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
`ifdef SPIKE_DISPATCH_TIMEOUT_EN
    to_d    = to_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Pop wins over done; done needs no enable.
        if (enable_i && !FIFO_empty_i) begin
          state_d = S_POP;
        end else if (filter_done_i && FIFO_empty_i) begin
          state_d = S_DONE;
        end
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        addr_d  = {1'b0, FIFO_r_data_i, {M{1'b1}}};
        state_d = S_REQ;
`ifdef SPIKE_DISPATCH_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      S_REQ: begin
        if (AERIN_ACK_i) begin
          state_d = S_ACKLOW;
`ifdef SPIKE_DISPATCH_TIMEOUT_EN
        end else if (to_q == TO_LAST) begin
          // Core never answered: drop the event.
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
`endif
        end
      end
      S_ACKLOW: begin
        if (!AERIN_ACK_i) begin
          state_d = S_IDLE;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Count stays visible until the filter
        // starts the next tick.
        if (!filter_done_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output strobes decoded from the next state so they are flop outputs.
  always_comb begin
    ren_d  = (state_d == S_POP);
    req_d  = (state_d == S_REQ);
    tick_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) &&
             (state_d != S_HOLD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      req_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      req_q   <= req_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SPIKE_DISPATCH_TIMEOUT_EN
  // ACK watchdog counter and sticky error flag.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      to_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      to_q   <= to_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err_o = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_err_o  = 1'b0;
`endif

  assign FIFO_r_en_o  = ren_q;
  assign AERIN_REQ_o  = req_q;
  assign AERIN_ADDR_o = addr_q;
  assign event_cnt_o  = cnt_q;
  assign tick_done_o  = tick_q;
  assign busy_o       = busy_q;

endmodule
